// File: rtl/mult_div_seq.sv
// Multicycle signed MULT/DIV sequencer owning the CPU Hi/Lo pair: radix-2 shift-add multiply and
// restoring divide, one iteration per clock. Define MULTDIV_UNSIGNED_EN to add the uns port.
module mult_div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
`ifdef MULTDIV_UNSIGNED_EN
   input  logic             uns,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

   state_e           state_q;
   logic             op_q;
   logic             sign_a_q;
   logic             sign_b_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] acc_hi_q;
   logic [WIDTH-1:0] acc_lo_q;

   logic             uns_sel;
`ifdef MULTDIV_UNSIGNED_EN
   assign uns_sel = uns;
`else
   assign uns_sel = 1'b0;
`endif

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   mul_sel;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic             div_ge;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic             sign_diff;

   always_comb begin
      a_neg     = a_in[WIDTH-1] & ~uns_sel;
      b_neg     = b_in[WIDTH-1] & ~uns_sel;
      // Negating the most negative value wraps to itself, which is its exact magnitude unsigned.
      a_abs     = a_neg ? -a_in : a_in;
      b_abs     = b_neg ? -b_in : b_in;
      mul_sum   = {1'b0, acc_hi_q} + {1'b0, opnd_q};
      mul_sel   = acc_lo_q[0] ? mul_sum : {1'b0, acc_hi_q};
      div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = div_shift >= {1'b0, opnd_q};
      sign_diff = sign_a_q ^ sign_b_q;
      prod      = {acc_hi_q, acc_lo_q};
      prod_fix  = sign_diff ? -prod : prod;
      quo_fix   = sign_diff ? -acc_lo_q : acc_lo_q;
      rem_fix   = sign_a_q ? -acc_hi_q : acc_hi_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         op_q     <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         cnt_q    <= '0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi_out   <= '0;
         lo_out   <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  op_q     <= op;
                  sign_a_q <= a_neg;
                  sign_b_q <= b_neg;
                  cnt_q    <= CW'(WIDTH);
                  acc_hi_q <= '0;
                  // MUL: multiplier shifts through acc_lo; DIV: dividend shifts out of acc_lo.
                  acc_lo_q <= op ? a_abs : b_abs;
                  opnd_q   <= op ? b_abs : a_abs;
                  if (op && (b_in == '0)) begin
                     state_q  <= StDone;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     state_q <= op ? StDiv : StMul;
                     busy    <= 1'b1;
                  end
               end else begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end
            end
            StMul: begin
               acc_hi_q <= mul_sel[WIDTH:1];
               acc_lo_q <= {mul_sel[0], acc_lo_q[WIDTH-1:1]};
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= StFix;
            end
            StDiv: begin
               acc_hi_q <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
               acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
               cnt_q    <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_q <= StFix;
            end
            StFix: begin
               if (op_q) begin
                  hi_out <= rem_fix;
                  lo_out <= quo_fix;
               end else begin
                  hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_out <= prod_fix[WIDTH-1:0];
               end
               state_q <= StDone;
               busy    <= 1'b0;
               done    <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
